// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-back cache controller.
// Sequences hits, write-backs and fills; owns per-set tree PLRU.
module cache_ctrl_nway #(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  localparam int W_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int S_W = $clog2(SETS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cpu_read,
  input  logic           cpu_write,
  output logic           cpu_resp,
  input  logic [S_W-1:0] set_idx,
  input  logic [WAYS-1:0] way_hit,
  input  logic [WAYS-1:0] way_valid,
  input  logic [WAYS-1:0] way_dirty,
  output logic           mem_read,
  output logic           mem_write,
  input  logic           mem_resp,
  output logic           mem_addr_sel,
  output logic [W_W-1:0] way_sel,
  output logic           ld_tag,
  output logic           ld_valid,
  output logic           ld_dirty,
  output logic           dirty_in,
  output logic           ld_data,
  output logic           data_src
);

  localparam int NODES = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL
  } state_t;

  state_t         state, state_d;
  logic [W_W-1:0] victim_q;
  logic [W_W-1:0] hit_way;
  logic [W_W-1:0] inv_way;
  logic [W_W-1:0] plru_vict;
  logic [W_W-1:0] vict;
  logic           has_inv;
  logic           vict_dirty;
  logic           req;
  logic           hit;
  logic           lru_upd;

  // Heap-ordered tree: node k has children 2k+1 and 2k+2.
  function automatic logic [NODES-1:0] plru_touch(
    input logic [NODES-1:0] t,
    input logic [W_W-1:0]   w
  );
    logic [NODES-1:0] r;
    r = t;
    for (int l = 0; l < W_W; l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if ((int'(w) >> (W_W - l)) == p)
          r[(1 << l) - 1 + p] = ~w[W_W-1-l];
      end
    end
    return r;
  endfunction

  function automatic logic [W_W-1:0] plru_victim(
    input logic [NODES-1:0] t
  );
    int   pre;
    logic b;
    pre = 0;
    for (int l = 0; l < W_W; l++) begin
      b = 1'b0;
      for (int p = 0; p < (1 << l); p++) begin
        if (pre == p)
          b = t[(1 << l) - 1 + p];
      end
      pre = 2 * pre + int'(b);
    end
    return W_W'(pre);
  endfunction

  assign req = cpu_read | cpu_write;
  assign hit = |way_hit;

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    has_inv = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_hit[i])
        hit_way = W_W'(i);
      if (!way_valid[i]) begin
        inv_way = W_W'(i);
        has_inv = 1'b1;
      end
    end
  end

  assign vict       = has_inv ? inv_way : plru_vict;
  assign vict_dirty = way_valid[vict] & way_dirty[vict];
  assign lru_upd    = (state == IDLE) & req & hit;

  if (WAYS > 1) begin : g_plru
    logic [SETS-1:0][NODES-1:0] plru_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        plru_q <= '0;
      else if (lru_upd)
        plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_way);
    end

    assign plru_vict = plru_victim(plru_q[set_idx]);
  end else begin : g_no_plru
    assign plru_vict = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      victim_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && req && !hit)
        victim_q <= vict;
    end
  end

  // Outputs are gated by rst_n so they drop the moment reset asserts.
  always_comb begin
    state_d      = state;
    cpu_resp     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    way_sel      = '0;
    ld_tag       = 1'b0;
    ld_valid     = 1'b0;
    ld_dirty     = 1'b0;
    dirty_in     = 1'b0;
    ld_data      = 1'b0;
    data_src     = 1'b0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (req && hit) begin
            cpu_resp = 1'b1;
            way_sel  = hit_way;
            if (cpu_write) begin
              ld_data  = 1'b1;
              ld_dirty = 1'b1;
              dirty_in = 1'b1;
            end
          end else if (req) begin
            state_d = vict_dirty ? WB : FILL;
          end
        end
        WB: begin
          mem_write    = 1'b1;
          mem_addr_sel = 1'b1;
          way_sel      = victim_q;
          if (mem_resp)
            state_d = FILL;
        end
        FILL: begin
          mem_read = 1'b1;
          way_sel  = victim_q;
          if (mem_resp) begin
            ld_data  = 1'b1;
            data_src = 1'b1;
            ld_tag   = 1'b1;
            ld_valid = 1'b1;
            ld_dirty = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
